// File: rtl/xmem_dma.sv
// Purpose: single-transfer DMA sequencer driving a Versat xmem port A (write stream in, read stream out).
// Latency: write lands 1 cycle after handshake; read data reaches m_valid 4 cycles after issue (2 mem + push).
// Backpressure: s_ready only in WRITE; reads throttled so FIFO + in-flight never exceeds FIFO_DEPTH.
//
// Ports:
//   clk, rst (async active-low)          - clock / reset
//   start, dir, base, len, busy, done    - transfer control (dir 0 = write, 1 = read)
//   s_data, s_valid, s_ready             - write stream into memory
//   m_data, m_valid, m_ready             - read stream out of the return FIFO
//   mem_valid, mem_we, mem_addr,
//   mem_wdata, mem_rdata                 - xmem port-A host interface (registered outputs)
module xmem_dma #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    // Occupancy including up to 3 in-flight reads fits in one extra bit since FIFO_DEPTH >= 4.
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FLUSH = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   n;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;

    // Read-return delay line: tracks reads through the memory's 2-cycle output path.
    logic              vld_d1;
    logic              vld_d2;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              rd_vld0;
    logic [1:0]        outstanding;
    logic [OCC_W-1:0]  occ;
    logic              push;
    logic              pop;
    logic              wr_hs;
    logic              rd_issue;
    logic              rd_fin;

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_FLUSH);
    assign s_ready = (state == S_WRITE);

    assign m_valid = (count != '0);
    assign m_data  = fifo_mem[rd_ptr];
    assign pop     = m_valid & m_ready;
    assign push    = vld_d2;

    assign rd_vld0     = mem_valid & ~mem_we;
    assign outstanding = {1'b0, rd_vld0} + {1'b0, vld_d1} + {1'b0, vld_d2};
    // A slot freed by this cycle's pop may be reused by this cycle's issue.
    assign occ         = OCC_W'(count) + OCC_W'(outstanding) - OCC_W'(pop);

    assign wr_hs    = s_valid & s_ready;
    assign rd_issue = (state == S_READ) && (n < len_q) && (occ < OCC_W'(FIFO_DEPTH));
    // Finish once everything issued has been delivered, counting the pop happening now.
    assign rd_fin   = (state == S_READ) && (n == len_q) && (outstanding == 2'd0)
                      && (count == CNT_W'(pop));

    // Control FSM and registered memory-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            n         <= '0;
            base_q    <= '0;
            len_q     <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            vld_d1    <= 1'b0;
            vld_d2    <= 1'b0;
        end else begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            vld_d1    <= rd_vld0;
            vld_d2    <= vld_d1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q <= base;
                        len_q  <= len;
                        n      <= '0;
                        if (len == '0) begin
                            state <= S_FLUSH;
                        end else if (dir) begin
                            state <= S_READ;
                        end else begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_hs) begin
                        mem_valid <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= base_q + n[ADDR_W-1:0];
                        mem_wdata <= s_data;
                        n         <= n + 1'b1;
                        if ((n + 1'b1) == len_q) begin
                            state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    state <= S_IDLE;
                end
                S_READ: begin
                    if (rd_issue) begin
                        mem_valid <= 1'b1;
                        mem_addr  <= base_q + n[ADDR_W-1:0];
                        n         <= n + 1'b1;
                    end
                    if (rd_fin) begin
                        state <= S_FLUSH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read-return FIFO; storage is cleared so m_data is 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= mem_rdata;
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The issue throttle guarantees room for every in-flight read.
    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (count == CNT_W'(FIFO_DEPTH))));

endmodule
